// File: rtl/nvdla_apb_cfg_master.sv
// Upstream APB master for the NVDLA config port: 2-deep command FIFO, one APB transfer per command.
// Optional ACCESS timeout abort is built when NVDLA_APB_CFG_TIMEOUT_EN is defined.
module nvdla_apb_cfg_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              csb_clk,
    input  logic              csb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t     state;
    cmd_t       fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_cnt;
    cmd_t       head;
    logic       push;
    logic       pop;
    logic       timeout_hit;

    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign cmd_ready = (fifo_cnt != 2'd2);
    assign busy      = (state != IDLE) || (fifo_cnt != 2'd0);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (fifo_cnt != 2'd0);
    assign head      = fifo_mem[rd_ptr];

    // NOTE: storage is deliberately not reset; an entry is only read after the count says it was written.
    always_ff @(posedge csb_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_t'{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge csb_clk or posedge csb_rst) begin
        if (csb_rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef NVDLA_APB_CFG_TIMEOUT_EN
    // Abort on the ACCESS cycle whose wait would bring the counter up to TIMEOUT.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;

    always_ff @(posedge csb_clk or posedge csb_rst) begin
        if (csb_rst) begin
            wait_cnt <= 16'd0;
        end else if (state == SETUP) begin
            wait_cnt <= 16'd0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = !pready && (wait_cnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge csb_clk or posedge csb_rst) begin
        if (csb_rst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        rsp_write <= head.write;
                        if (head.addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error and never touch the APB bus.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            paddr  <= head.addr;
                            pwrite <= head.write;
                            pwdata <= head.write ? head.wdata : '0;
                            psel   <= 1'b1;
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !pready;
                        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_apb_cfg_master.sv
// Directed self-checking bench for nvdla_apb_cfg_master; inputs change and outputs are sampled on negedges.
// The timeout scenario follows NVDLA_APB_CFG_TIMEOUT_EN when it is defined.
module tb_nvdla_apb_cfg_master;

    logic        csb_clk = 1'b0;
    logic        csb_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int          en_cnt;
    int          got;
    int          seen;
    int          t_rsp [3];
    logic        w_rsp [3];
    logic [31:0] d_rsp [3];
    logic        e_rsp [3];

    nvdla_apb_cfg_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .csb_clk   (csb_clk),
        .csb_rst   (csb_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .busy      (busy)
    );

    always #5 csb_clk = ~csb_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge csb_clk);
    endtask

    initial begin
        csb_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        repeat (2) cyc();

        // Reset state
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        csb_rst = 1'b0;
        cyc();

        // Minimum-latency write
        pready    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_5004;
        cmd_wdata = 32'hA5A5_1234;
        cyc();
        cmd_valid = 1'b0;
        check("wr_e0_psel", psel, 0);
        check("wr_e0_busy", busy, 1);
        cyc();
        check("wr_e1_psel", psel, 1);
        check("wr_e1_penable", penable, 0);
        check("wr_e1_paddr", paddr, 32'h0000_5004);
        check("wr_e1_pwdata", pwdata, 32'hA5A5_1234);
        check("wr_e1_pwrite", pwrite, 1);
        cyc();
        check("wr_e2_psel", psel, 1);
        check("wr_e2_penable", penable, 1);
        check("wr_e2_rsp_valid", rsp_valid, 0);
        cyc();
        check("wr_e3_rsp_valid", rsp_valid, 1);
        check("wr_e3_psel", psel, 0);
        check("wr_e3_penable", penable, 0);
        check("wr_rsp_write", rsp_write, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("wr_done_rsp_valid", rsp_valid, 0);
        check("wr_done_busy", busy, 0);

        // Read with five wait states
        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_1000;
        cmd_wdata = 32'h1234_5678;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        check("rd_setup_psel", psel, 1);
        check("rd_setup_paddr", paddr, 32'h0000_1000);
        check("rd_setup_pwrite", pwrite, 0);
        check("rd_setup_pwdata", pwdata, 0);
        en_cnt = 0;
        for (int i = 0; i < 50 && !rsp_valid; i++) begin
            cyc();
            if (penable) en_cnt++;
            if (en_cnt == 6) begin
                pready = 1'b1;
                prdata = 32'hDEAD_BEEF;
            end
        end
        check("rd_penable_cycles", en_cnt, 6);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_rsp_write", rsp_write, 0);
        pready    = 1'b0;
        prdata    = '0;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // Misaligned read: error response, no APB cycle
        pready    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0102;
        cyc();
        cmd_valid = 1'b0;
        check("mis_e0_rsp_valid", rsp_valid, 0);
        check("mis_e0_psel", psel, 0);
        cyc();
        check("mis_e1_rsp_valid", rsp_valid, 1);
        check("mis_e1_psel", psel, 0);
        check("mis_rsp_err", rsp_err, 1);
        check("mis_rsp_rdata", rsp_rdata, 0);
        check("mis_rsp_write", rsp_write, 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("mis_done_rsp_valid", rsp_valid, 0);
        check("mis_done_psel", psel, 0);

        // Three back-to-back commands with responses stalled
        pready    = 1'b1;
        prdata    = 32'hCAFE_F00D;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_2000;
        cmd_wdata = 32'h1111_1111;
        cyc();
        check("b2b_ready_a", cmd_ready, 1);
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_3004;
        cmd_wdata = 32'h2222_2222;
        cyc();
        check("b2b_ready_b", cmd_ready, 1);
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_4008;
        cmd_wdata = 32'h3333_3333;
        cyc();
        cmd_valid = 1'b0;
        check("b2b_ready_full", cmd_ready, 0);
        repeat (3) cyc();
        check("b2b_stall_rsp_valid", rsp_valid, 1);
        check("b2b_stall_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            if (rsp_valid) begin
                t_rsp[got] = i;
                w_rsp[got] = rsp_write;
                d_rsp[got] = rsp_rdata;
                e_rsp[got] = rsp_err;
                got++;
            end
            cyc();
        end
        rsp_ready = 1'b0;
        check("b2b_count", got, 3);
        check("b2b_r0", {w_rsp[0], e_rsp[0], d_rsp[0]}, {1'b1, 1'b0, 32'h0});
        check("b2b_r1", {w_rsp[1], e_rsp[1], d_rsp[1]}, {1'b0, 1'b0, 32'hCAFE_F00D});
        check("b2b_r2", {w_rsp[2], e_rsp[2], d_rsp[2]}, {1'b1, 1'b0, 32'h0});
        check("b2b_gap_01", t_rsp[1] - t_rsp[0], 4);
        check("b2b_gap_12", t_rsp[2] - t_rsp[1], 4);
        check("b2b_done_busy", busy, 0);

        // Stuck pready
        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_7000;
        cyc();
        cmd_valid = 1'b0;
        cyc();
`ifdef NVDLA_APB_CFG_TIMEOUT_EN
        en_cnt = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            cyc();
            if (penable) en_cnt++;
        end
        check("to_penable_cycles", en_cnt, 8);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel", psel, 0);
`else
        repeat (20) cyc();
        check("stuck_penable", penable, 1);
        check("stuck_busy", busy, 1);
        check("stuck_rsp_valid", rsp_valid, 0);
        pready = 1'b1;
        cyc();
        check("stuck_rel_rsp_valid", rsp_valid, 1);
        check("stuck_rel_rsp_err", rsp_err, 0);
        check("stuck_rel_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
`endif
        pready    = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("stuck_done_busy", busy, 0);

        // Reset during ACCESS with one command queued
        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_5000;
        cyc();
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_6000;
        cmd_wdata = 32'h6666_6666;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        check("rstx_pre_penable", penable, 1);
        check("rstx_pre_busy", busy, 1);
        #2 csb_rst = 1'b1;
        #1;
        check("rstx_psel", psel, 0);
        check("rstx_penable", penable, 0);
        check("rstx_rsp_valid", rsp_valid, 0);
        check("rstx_busy", busy, 0);
        check("rstx_cmd_ready", cmd_ready, 1);
        cyc();
        csb_rst   = 1'b0;
        pready    = 1'b1;
        rsp_ready = 1'b1;
        seen      = 0;
        repeat (12) begin
            cyc();
            if (rsp_valid || psel) seen = 1;
        end
        check("rstx_no_activity", seen, 0);
        check("rstx_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
